// File: rtl/csa_mult_pkg.sv
// Shared types and constants for the carry-save serial multiplier.
package csa_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_row.sv
// Vector row of 3:2 compressors: three addends in, bitwise sum and unshifted majority carry out.
module csa_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_serial_multiplier.sv
// Sequential unsigned multiplier: one partial-product row per cycle into a carry-save accumulator.
// Optional macro CSA_SERIAL_MULTIPLIER_EARLY_TERM_EN ends accumulation once the remaining multiplier bits are zero.
module csa_serial_multiplier
    import csa_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [PW-1:0]      a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      sum_q, sum_d;
    logic [PW-1:0]      carry_q, carry_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic [PW-1:0]      product_q, product_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [PW-1:0]      pp;
    logic [PW-1:0]      row_sum;
    logic [PW-1:0]      row_carry;
    logic               last_row;

    assign pp = b_q[0] ? a_q : '0;

    csa_row #(.WIDTH(PW)) u_row (
        .x     (sum_q),
        .y     (carry_q),
        .z     (pp),
        .sum   (row_sum),
        .carry (row_carry)
    );

`ifdef CSA_SERIAL_MULTIPLIER_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain beyond the current row.
    assign last_row = ((b_q >> 1) == '0) || (i_q == CNT_W'(WIDTH - 1));
`else
    assign last_row = (i_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        i_d       = i_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = {{WIDTH{1'b0}}, a};
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = '0;
                    i_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Carry out of the top bit is always zero because the product fits in PW bits.
                sum_d   = row_sum;
                carry_d = row_carry << 1;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                i_d     = i_q + CNT_W'(1);
                if (last_row) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                product_d = sum_q + carry_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == ACCUM) || (state_d == RESOLVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            i_q         <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            i_q         <= i_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule
